// File: rtl/mux_stream_arb_pkg.sv
// ============================================================================
//  Module   : hack_pkg
//  Purpose  : Shared constants and types for the Hack stream arbiter/mux.
//             MODE_RR / MODE_FIXED select the arbitration policy and
//             chan_idx_t is wide enough to name any of up to MAX_NCH channels.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hack_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  localparam int MAX_NCH    = 16;
  localparam int CHAN_IDX_W = $clog2(MAX_NCH);

  typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

endpackage

`default_nettype wire

// File: rtl/mux_stream_arb_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Purely combinational arbiter producing a one-hot grant over the
//             request vector. MODE_RR searches from ptr upward with wrap;
//             MODE_FIXED picks the lowest requesting index.
//  Ports    : req       in   NCH     request per channel
//             ptr       in   IDX_W   round-robin start index (MODE_RR only)
//             grant     out  NCH     one-hot grant, zero when no request
//             grant_idx out  IDX_W   binary index of the granted channel
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import hack_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Walk the channels in priority order; the first requester seen wins.
  // In round-robin mode the walk starts at ptr and wraps past NCH-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (MODE == MODE_FIXED) begin
        w_cand = IDX_W'(k);
      end else begin
        w_cand = IDX_W'((int'(ptr) + k) % NCH);
      end
      if (!w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_stream_arb.sv
// ============================================================================
//  Module   : mux_stream_arb
//  Purpose  : NCH-to-1 valid/ready stream multiplexer with an internal
//             arbiter and a registered output stage (1 cycle latency,
//             1 word/cycle sustained). Counts accepted input transfers.
//  Ports    : clk        in   1            rising-edge clock
//             rst_n      in   1            async assert, active-low reset
//             in_data    in   NCH*WIDTH    channel i at [i*WIDTH +: WIDTH]
//             in_valid   in   NCH          channel i has data
//             in_ready   out  NCH          channel i accepted this cycle
//             out_data   out  WIDTH        registered selected word
//             out_chan   out  $clog2(NCH)  source channel of out_data
//             out_valid  out  1            out_data/out_chan valid
//             out_ready  in   1            consumer accepts output
//             xfer_cnt   out  CNT_W        saturating transfer count
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_stream_arb
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH*WIDTH-1:0]       in_data,
  input  logic [NCH-1:0]             in_valid,
  output logic [NCH-1:0]             in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NCH)-1:0]     out_chan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           xfer_cnt
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic             w_load;
  logic             w_xfer;
  logic [NCH-1:0]   w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .NCH   (NCH),
    .MODE  (MODE),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // The output register can take a word when empty or being drained now.
  assign w_load   = !r_out_valid || out_ready;
  assign in_ready = w_load ? w_grant : '0;
  // The grant is a subset of in_valid, so any grant bit means a transfer.
  assign w_xfer   = w_load && (|w_grant);

  assign w_ptr_next = (w_grant_idx == IDX_W'(NCH - 1)) ? '0
                                                       : w_grant_idx + IDX_W'(1);

  // AND-OR mux over the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_grant_idx;
        r_out_valid <= 1'b1;
        if (MODE == MODE_RR) begin
          r_rr_ptr <= w_ptr_next;
        end
        if (r_xfer_cnt != {CNT_W{1'b1}}) begin
          r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
      end else if (out_ready) begin
        // Drain: data/chan keep their last value, only valid drops.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign xfer_cnt  = r_xfer_cnt;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid && !out_ready) |=>
      (r_out_valid && $stable(r_out_data) && $stable(r_out_chan)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_stream_arb.sv
// ============================================================================
//  Module   : tb_mux_stream_arb
//  Purpose  : Self-checking bench for mux_stream_arb. Three instances share
//             one stimulus: round-robin (CNT_W 16), fixed priority, and
//             round-robin with CNT_W 4 for counter saturation.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_stream_arb;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  logic [N-1:0]   rdy_rr,   rdy_fp,   rdy_sat;
  logic [W-1:0]   data_rr,  data_fp,  data_sat;
  logic [1:0]     chan_rr,  chan_fp,  chan_sat;
  logic           val_rr,   val_fp,   val_sat;
  logic [15:0]    cnt_rr,   cnt_fp;
  logic [3:0]     cnt_sat;

  mux_stream_arb #(.WIDTH(W), .NCH(N), .MODE(0), .CNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_rr), .out_data(data_rr), .out_chan(chan_rr),
    .out_valid(val_rr), .out_ready(out_ready), .xfer_cnt(cnt_rr));

  mux_stream_arb #(.WIDTH(W), .NCH(N), .MODE(1), .CNT_W(16)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_fp), .out_data(data_fp), .out_chan(chan_fp),
    .out_valid(val_fp), .out_ready(out_ready), .xfer_cnt(cnt_fp));

  mux_stream_arb #(.WIDTH(W), .NCH(N), .MODE(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_sat), .out_data(data_sat), .out_chan(chan_sat),
    .out_valid(val_sat), .out_ready(out_ready), .xfer_cnt(cnt_sat));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    logic        ordy;
    logic [3:0]  erdy;
    logic        evalid;
    logic [15:0] edata;
    logic [1:0]  echan;
  } vec_t;

  vec_t vecs[16];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_cnt = 0;

  // Standard all-channel payload: channel c carries 16'h1111*(c+1).
  localparam logic [63:0] ALLD = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  function automatic vec_t mk(input logic [3:0] v, input logic [63:0] d,
                              input logic o, input logic [3:0] er,
                              input logic ev, input logic [15:0] ed,
                              input logic [1:0] ec);
    vec_t r;
    r.valid = v; r.data = d; r.ordy = o; r.erdy = er;
    r.evalid = ev; r.edata = ed; r.echan = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Called just after a rising edge: drive, check in_ready, clock, check outputs.
  task automatic apply_vec(input int i);
    in_valid  = vecs[i].valid;
    in_data   = vecs[i].data;
    out_ready = vecs[i].ordy;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(rdy_rr), 32'(vecs[i].erdy));
    @(posedge clk); #1;
    if (vecs[i].erdy != 4'b0) model_cnt++;
    chk($sformatf("v%0d out_valid", i), 32'(val_rr),  32'(vecs[i].evalid));
    chk($sformatf("v%0d out_data", i),  32'(data_rr), 32'(vecs[i].edata));
    chk($sformatf("v%0d out_chan", i),  32'(chan_rr), 32'(vecs[i].echan));
    chk($sformatf("v%0d xfer_cnt", i),  32'(cnt_rr),  32'(model_cnt));
    chk($sformatf("v%0d sat_cnt", i),   32'(cnt_sat), 32'(sat15(model_cnt)));
  endtask

  initial begin
    // Single-channel and signed passthrough.
    vecs[0] = mk(4'b0001, {48'h0, 16'd3567},          1'b1, 4'b0001, 1'b1, 16'd3567, 2'd0);
    vecs[1] = mk(4'b0010, {32'h0, 16'd1095, 16'h0},   1'b1, 4'b0010, 1'b1, 16'd1095, 2'd1);
    vecs[2] = mk(4'b0100, {16'h0, 16'h8DEF, 32'h0},   1'b1, 4'b0100, 1'b1, 16'h8DEF, 2'd2);
    // Round robin, all valid: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      vecs[3+k] = mk(4'b1111, ALLD, 1'b1, 4'(1 << (k % 4)), 1'b1,
                     16'(16'h1111 * ((k % 4) + 1)), 2'(k % 4));
    end
    // Channel 1 drops: 0,2,3,0.
    vecs[11] = mk(4'b1101, ALLD, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0);
    vecs[12] = mk(4'b1101, ALLD, 1'b1, 4'b0100, 1'b1, 16'h3333, 2'd2);
    vecs[13] = mk(4'b1101, ALLD, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3);
    vecs[14] = mk(4'b1101, ALLD, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0);
    // Nothing valid: drains, data/chan hold.
    vecs[15] = mk(4'b0000, ALLD, 1'b1, 4'b0000, 1'b0, 16'h1111, 2'd0);

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(val_rr),  32'd0);
    chk("reset out_data",  32'(data_rr), 32'd0);
    chk("reset out_chan",  32'(chan_rr), 32'd0);
    chk("reset xfer_cnt",  32'(cnt_rr),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) apply_vec(i);

    // Asynchronous reset while holding a word.
    chk("pre-reset out_valid", 32'(val_rr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(val_rr),  32'd0);
    chk("async rst xfer_cnt",  32'(cnt_rr),  32'd0);
    chk("async rst out_data",  32'(data_rr), 32'd0);
    model_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 3; i < 16; i++) apply_vec(i);

    // Backpressure: rr_ptr is 1 here, so channel 1 loads first.
    in_valid = 4'b1111; in_data = ALLD; out_ready = 1'b1;
    @(posedge clk); #1;
    model_cnt++;
    chk("bp load chan", 32'(chan_rr), 32'd1);
    chk("bp load data", 32'(data_rr), 32'h2222);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d in_ready", c), 32'(rdy_rr), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", c), 32'(val_rr),  32'd1);
      chk($sformatf("bp%0d out_data", c),  32'(data_rr), 32'h2222);
      chk($sformatf("bp%0d out_chan", c),  32'(chan_rr), 32'd1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("resume%0d in_ready", k), 32'(rdy_rr), 32'(1 << ((2 + k) % 4)));
      @(posedge clk); #1;
      model_cnt++;
      chk($sformatf("resume%0d out_valid", k), 32'(val_rr),  32'd1);
      chk($sformatf("resume%0d out_chan", k),  32'(chan_rr), 32'((2 + k) % 4));
      chk($sformatf("resume%0d out_data", k),  32'(data_rr), 32'(16'h1111 * (((2 + k) % 4) + 1)));
    end

    // Fixed priority: channels 0 and 3 valid, channel 0 always wins.
    in_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("fp%0d in_ready", k), 32'(rdy_fp), 32'b0001);
      @(posedge clk); #1;
      model_cnt++;
      chk($sformatf("fp%0d out_chan", k),  32'(chan_fp), 32'd0);
      chk($sformatf("fp%0d out_valid", k), 32'(val_fp),  32'd1);
      chk($sformatf("fp%0d out_data", k),  32'(data_fp), 32'h1111);
    end

    chk("final xfer_cnt",  32'(cnt_rr),  32'(model_cnt));
    chk("final sat_cnt",   32'(cnt_sat), 32'd15);

    in_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
